controlador_posicionamento: RTL and testbench
=============================================

Name: controlador_posicionamento

Overview:
Sequences the fleet-placement phase for both players. Captures each placement request from the player inputs and presents it to the piece validator, which builds the piece vector, checks borders, checks memory collisions and writes the piece to the player's memory. The block then waits for the validator's result, advances through a fixed fleet order, switches player, and flags completion to the game FSM. It sits between the input debouncer/game FSM and the validator.

Parameters:
NUM_PECAS, 11, pieces per player; equals the validator memory depth.
TIMEOUT_CICLOS, 64, validator response window in clk cycles before a timeout error.
LARG_TIMEOUT, 7, timeout counter width; must satisfy 2^LARG_TIMEOUT > TIMEOUT_CICLOS.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
iniciar  in  1  one-cycle pulse; starts the placement phase
confirmar  in  1  level from the debounced button; the rising edge is used internally
direcao_in  in  1  0 = horizontal, 1 = vertical
orientacao_in  in  3  seaplane orientation, 0..3
x_in  in  4  column
y_in  in  4  row
val_ready  in  1  validator: piece accepted and written (pulse or level)
val_conflito_borda  in  1  validator: border conflict
val_conflito_mem  in  1  validator: memory conflict
val_enable  out  1  validator enable
val_tipo  out  3  piece type for the validator
val_direcao  out  1  latched direction
val_orientacao  out  3  latched orientation
val_x  out  4  latched column
val_y  out  4  latched row
val_jogador  out  1  current player
indice_peca  out  4  index of the piece being placed, 0..NUM_PECAS-1
erro_borda  out  1  sticky error flag
erro_memoria  out  1  sticky error flag
erro_timeout  out  1  sticky error flag
ocupado  out  1  high from start of a validation until the validator responds
fase_concluida  out  1  high once both fleets are placed

Behaviour:
- Reset (async, rst_n=0): state OCIOSO. All outputs 0. Latches, index, player and timeout counter cleared.
- Fleet order, by indice_peca:
  - 0: tipo 0 (porta-aviões)
  - 1-2: tipo 1 (encouraçado)
  - 3-4: tipo 2 (hidroavião)
  - 5-7: tipo 3 (cruzador)
  - 8-10: tipo 4 (submarino)
  - val_tipo is a combinational decode of indice_peca.
- Edge detect: conf_prev is registered. The confirm event is confirmar & ~conf_prev.

States:
- OCIOSO
  - iniciar -> ESPERA. jogador=0, indice=0, fase_concluida=0.
  - Confirm events are ignored in this state.
- ESPERA
  - On a confirm event: latch direcao_in, orientacao_in, x_in, y_in into the val_* registers; clear all erro_*; go to VALIDA next cycle.
- VALIDA
  - val_enable=1 for exactly one cycle; ocupado=1; timeout counter cleared.
  - -> AGUARDA.
- AGUARDA
  - val_enable=0; ocupado=1; timeout counter increments every cycle.
  - Priority when several inputs are high in the same cycle: val_conflito_borda > val_conflito_mem > val_ready > timeout.
  - val_conflito_borda -> erro_borda=1 -> ESPERA.
  - val_conflito_mem -> erro_memoria=1 -> ESPERA.
  - val_ready -> AVANCA.
  - Counter reaches TIMEOUT_CICLOS-1 -> erro_timeout=1 -> ESPERA.
- AVANCA (one cycle), ocupado=0:
  - indice<NUM_PECAS-1: indice+1 -> ESPERA.
  - indice==NUM_PECAS-1 and jogador=0: indice=0, jogador=1 -> ESPERA.
  - indice==NUM_PECAS-1 and jogador=1: fase_concluida=1 -> FIM.
- FIM
  - Holds all outputs.
  - iniciar restarts the phase as in OCIOSO.

Timing and boundary rules:
- Latency: confirm edge at cycle n gives val_enable at n+2. A response seen at cycle m produces the updated flag or index at m+1.
- Confirm events outside ESPERA are dropped, never queued. A button held from ESPERA into AGUARDA does not retrigger.
- Error flags are sticky until the next confirm event or iniciar. The same piece is retried; indice_peca does not change on any error.
- val_x, val_y and val_direcao stay stable from VALIDA until the next latch.
- iniciar in any state other than OCIOSO or FIM is ignored.
- Reset mid-AGUARDA returns to OCIOSO immediately. The validator's in-flight write is not tracked; the game FSM must clear memory.
- indice_peca never exceeds NUM_PECAS-1. Values 11-15 are unreachable, and the tipo decode defaults to 4.

Decomposition:
- Shared package holds:
  - piece type constants PORTA_AVIOES=0, ENCOURACADO=1, HIDROAVIAO=2, CRUZADOR=3, SUBMARINO=4;
  - the direction encoding;
  - the fleet-order table, used by both this block and the validator testbench.
- One sub-module, detector_borda_subida, provides the confirm edge detect.

Test Plan:
- Reset, iniciar, confirm with x=2, y=3, dir=0 -> val_enable pulses 2 cycles after the edge with val_tipo=0, val_x=2, val_y=3; val_ready -> indice_peca=1.
- val_conflito_borda during AGUARDA -> erro_borda=1, indice_peca unchanged at 0, state ESPERA; next confirm clears erro_borda.
- val_ready and val_conflito_mem asserted in the same cycle -> erro_memoria=1, no advance.
- No validator response -> erro_timeout=1 exactly 64 cycles after val_enable.
- 22 accepted placements -> jogador toggles to 1 after the 11th; fase_concluida=1 after the 22nd; further confirms are ignored.
- rst_n low while in AGUARDA -> all outputs 0 asynchronously; after release, confirm is ignored until iniciar.

Source files
------------

// File: rtl/controlador_posicionamento_pkg.sv
// Shared types for the fleet-placement phase: piece types, direction encoding,
// the fixed fleet order and the sequencer state set.
package controlador_posicionamento_pkg;

  typedef enum logic [2:0] {
    PORTA_AVIOES = 3'd0,
    ENCOURACADO  = 3'd1,
    HIDROAVIAO   = 3'd2,
    CRUZADOR     = 3'd3,
    SUBMARINO    = 3'd4
  } tipo_peca_e;

  localparam logic DIR_HORIZONTAL = 1'b0;
  localparam logic DIR_VERTICAL   = 1'b1;

  localparam int TAM_FROTA = 11;

  // Placement order of one fleet, indexed by piece number.
  localparam tipo_peca_e ORDEM_FROTA [TAM_FROTA] = '{
    PORTA_AVIOES,
    ENCOURACADO, ENCOURACADO,
    HIDROAVIAO, HIDROAVIAO,
    CRUZADOR, CRUZADOR, CRUZADOR,
    SUBMARINO, SUBMARINO, SUBMARINO
  };

  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA,
    VALIDA,
    AGUARDA,
    AVANCA,
    FIM
  } estado_e;

  // Indices past the end of the fleet (unreachable) decode to SUBMARINO.
  function automatic tipo_peca_e tipo_da_peca(input logic [3:0] indice);
    tipo_peca_e tipo;
    tipo = SUBMARINO;
    for (int i = 0; i < TAM_FROTA; i++) begin
      if (indice == 4'(i)) tipo = ORDEM_FROTA[i];
    end
    return tipo;
  endfunction

endpackage

// File: rtl/controlador_posicionamento_detector.sv
// Rising-edge detector for the debounced confirm button.
module detector_borda_subida (
  input  logic clk,
  input  logic rst_n,
  input  logic sinal_i,
  output logic borda_o
);

  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sinal_i;
  end

  assign borda_o = sinal_i & ~prev_q;

endmodule

// File: rtl/controlador_posicionamento.sv
// Fleet-placement sequencer: latches each placement request, hands it to the
// piece validator, waits for its verdict and walks both players' fleets.
module controlador_posicionamento
  import controlador_posicionamento_pkg::*;
#(
  parameter int NUM_PECAS      = 11,
  parameter int TIMEOUT_CICLOS = 64,
  parameter int LARG_TIMEOUT   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       direcao_in,
  input  logic [2:0] orientacao_in,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       val_ready,
  input  logic       val_conflito_borda,
  input  logic       val_conflito_mem,
  output logic       val_enable,
  output logic [2:0] val_tipo,
  output logic       val_direcao,
  output logic [2:0] val_orientacao,
  output logic [3:0] val_x,
  output logic [3:0] val_y,
  output logic       val_jogador,
  output logic [3:0] indice_peca,
  output logic       erro_borda,
  output logic       erro_memoria,
  output logic       erro_timeout,
  output logic       ocupado,
  output logic       fase_concluida
);

  localparam logic [3:0]              ULTIMA_PECA = 4'(NUM_PECAS - 1);
  localparam logic [LARG_TIMEOUT-1:0] CONT_MAX    = LARG_TIMEOUT'(TIMEOUT_CICLOS - 1);

  estado_e                 estado_q;
  logic                    evento_conf;
  logic                    val_enable_q;
  logic                    direcao_q;
  logic [2:0]              orientacao_q;
  logic [3:0]              x_q;
  logic [3:0]              y_q;
  logic                    jogador_q;
  logic [3:0]              indice_q;
  logic                    erro_borda_q;
  logic                    erro_memoria_q;
  logic                    erro_timeout_q;
  logic                    ocupado_q;
  logic                    fase_q;
  logic [LARG_TIMEOUT-1:0] cont_q;

  detector_borda_subida u_detector (
    .clk     (clk),
    .rst_n   (rst_n),
    .sinal_i (confirmar),
    .borda_o (evento_conf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= OCIOSO;
      val_enable_q   <= 1'b0;
      direcao_q      <= 1'b0;
      orientacao_q   <= '0;
      x_q            <= '0;
      y_q            <= '0;
      jogador_q      <= 1'b0;
      indice_q       <= '0;
      erro_borda_q   <= 1'b0;
      erro_memoria_q <= 1'b0;
      erro_timeout_q <= 1'b0;
      ocupado_q      <= 1'b0;
      fase_q         <= 1'b0;
      cont_q         <= '0;
    end else begin
      unique case (estado_q)
        OCIOSO, FIM: begin
          if (iniciar) begin
            estado_q       <= ESPERA;
            jogador_q      <= 1'b0;
            indice_q       <= '0;
            fase_q         <= 1'b0;
            erro_borda_q   <= 1'b0;
            erro_memoria_q <= 1'b0;
            erro_timeout_q <= 1'b0;
          end
        end

        ESPERA: begin
          if (evento_conf) begin
            direcao_q      <= direcao_in;
            orientacao_q   <= orientacao_in;
            x_q            <= x_in;
            y_q            <= y_in;
            erro_borda_q   <= 1'b0;
            erro_memoria_q <= 1'b0;
            erro_timeout_q <= 1'b0;
            estado_q       <= VALIDA;
          end
        end

        VALIDA: begin
          val_enable_q <= 1'b1;
          ocupado_q    <= 1'b1;
          cont_q       <= '0;
          estado_q     <= AGUARDA;
        end

        AGUARDA: begin
          val_enable_q <= 1'b0;
          // Border beats memory beats ready beats timeout.
          if (val_conflito_borda) begin
            erro_borda_q <= 1'b1;
            ocupado_q    <= 1'b0;
            estado_q     <= ESPERA;
          end else if (val_conflito_mem) begin
            erro_memoria_q <= 1'b1;
            ocupado_q      <= 1'b0;
            estado_q       <= ESPERA;
          end else if (val_ready) begin
            ocupado_q <= 1'b0;
            estado_q  <= AVANCA;
            if (indice_q != ULTIMA_PECA) begin
              indice_q <= indice_q + 4'd1;
            end else if (!jogador_q) begin
              indice_q  <= '0;
              jogador_q <= 1'b1;
            end else begin
              fase_q <= 1'b1;
            end
          end else if (cont_q == CONT_MAX) begin
            erro_timeout_q <= 1'b1;
            ocupado_q      <= 1'b0;
            estado_q       <= ESPERA;
          end else begin
            cont_q <= cont_q + LARG_TIMEOUT'(1);
          end
        end

        // Index/player already moved on the ready edge; this cycle only routes onward.
        AVANCA: estado_q <= fase_q ? FIM : ESPERA;

        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign val_enable     = val_enable_q;
  assign val_tipo       = tipo_da_peca(indice_q);
  assign val_direcao    = direcao_q;
  assign val_orientacao = orientacao_q;
  assign val_x          = x_q;
  assign val_y          = y_q;
  assign val_jogador    = jogador_q;
  assign indice_peca    = indice_q;
  assign erro_borda     = erro_borda_q;
  assign erro_memoria   = erro_memoria_q;
  assign erro_timeout   = erro_timeout_q;
  assign ocupado        = ocupado_q;
  assign fase_concluida = fase_q;

endmodule

// File: tb/tb_controlador_posicionamento.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// a randomized full phase against a behavioural fleet/player model.
module tb_controlador_posicionamento;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iniciar = 1'b0;
  logic       confirmar = 1'b0;
  logic       direcao_in = 1'b0;
  logic [2:0] orientacao_in = '0;
  logic [3:0] x_in = '0;
  logic [3:0] y_in = '0;
  logic       val_ready = 1'b0;
  logic       val_conflito_borda = 1'b0;
  logic       val_conflito_mem = 1'b0;
  logic       val_enable;
  logic [2:0] val_tipo;
  logic       val_direcao;
  logic [2:0] val_orientacao;
  logic [3:0] val_x;
  logic [3:0] val_y;
  logic       val_jogador;
  logic [3:0] indice_peca;
  logic       erro_borda;
  logic       erro_memoria;
  logic       erro_timeout;
  logic       ocupado;
  logic       fase_concluida;

  controlador_posicionamento dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .iniciar            (iniciar),
    .confirmar          (confirmar),
    .direcao_in         (direcao_in),
    .orientacao_in      (orientacao_in),
    .x_in               (x_in),
    .y_in               (y_in),
    .val_ready          (val_ready),
    .val_conflito_borda (val_conflito_borda),
    .val_conflito_mem   (val_conflito_mem),
    .val_enable         (val_enable),
    .val_tipo           (val_tipo),
    .val_direcao        (val_direcao),
    .val_orientacao     (val_orientacao),
    .val_x              (val_x),
    .val_y              (val_y),
    .val_jogador        (val_jogador),
    .indice_peca        (indice_peca),
    .erro_borda         (erro_borda),
    .erro_memoria       (erro_memoria),
    .erro_timeout       (erro_timeout),
    .ocupado            (ocupado),
    .fase_concluida     (fase_concluida)
  );

  always #5 clk = ~clk;

  typedef enum int {R_READY, R_BORDA, R_MEM, R_READY_MEM, R_ALL, R_NONE} resp_e;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       d;
    logic [2:0] o;
    resp_e      r;
    int         tipo;
    int         idx;
    logic       eb;
    logic       em;
  } vetor_t;

  int n_checks = 0;
  int n_erros  = 0;

  // Behavioural model: position in the two fleets plus sticky flags.
  int   m_idx, m_jog;
  logic m_fase, m_eb, m_em, m_et;

  task automatic check(input string nome, input logic [31:0] real_v, input logic [31:0] esperado);
    n_checks++;
    if (real_v !== esperado) begin
      n_erros++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, real_v, esperado, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_tipo(input int idx);
    if (idx == 0)      return 0;
    else if (idx <= 2) return 1;
    else if (idx <= 4) return 2;
    else if (idx <= 7) return 3;
    else               return 4;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_jog = 0; m_fase = 1'b0;
    m_eb = 1'b0; m_em = 1'b0; m_et = 1'b0;
  endtask

  task automatic model_apply(input resp_e r);
    if (r == R_BORDA || r == R_ALL)  m_eb = 1'b1;
    else if (r == R_MEM || r == R_READY_MEM) m_em = 1'b1;
    else if (r == R_READY) begin
      if (m_idx < 10) m_idx++;
      else if (m_jog == 0) begin m_idx = 0; m_jog = 1; end
      else m_fase = 1'b1;
    end else m_et = 1'b1;
  endtask

  task automatic check_model(input string ctx);
    check({ctx, ".indice"}, indice_peca, m_idx);
    check({ctx, ".jogador"}, val_jogador, m_jog);
    check({ctx, ".tipo"}, val_tipo, model_tipo(m_idx));
    check({ctx, ".erros"}, {erro_borda, erro_memoria, erro_timeout}, {m_eb, m_em, m_et});
    check({ctx, ".fase"}, fase_concluida, m_fase);
    check({ctx, ".ocupado"}, ocupado, 0);
  endtask

  task automatic watch_no_enable(input int n, input string nome);
    logic visto;
    visto = 1'b0;
    repeat (n) begin
      tick();
      visto |= val_enable;
    end
    check(nome, visto, 0);
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // One full placement attempt, with the validator answering as r dictates.
  task automatic place(input logic [3:0] x, input logic [3:0] y, input logic d,
                       input logic [2:0] o, input resp_e r, output int tipo_visto);
    x_in = x; y_in = y; direcao_in = d; orientacao_in = o;
    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    check("enable_cedo", val_enable, 0);
    tick();
    tipo_visto = int'(val_tipo);
    check("enable", val_enable, 1);
    check("tipo", val_tipo, model_tipo(m_idx));
    check("latch", {val_x, val_y, val_direcao, val_orientacao}, {x, y, d, o});
    check("ocupado_validando", ocupado, 1);
    check("erros_limpos", {erro_borda, erro_memoria, erro_timeout}, 0);
    m_eb = 1'b0; m_em = 1'b0; m_et = 1'b0;
    if (r == R_NONE) begin
      repeat (TIMEOUT - 1) tick();
      check("timeout_cedo", erro_timeout, 0);
      check("ocupado_aguarda", ocupado, 1);
      tick();
    end else begin
      val_ready          = (r == R_READY || r == R_READY_MEM || r == R_ALL);
      val_conflito_borda = (r == R_BORDA || r == R_ALL);
      val_conflito_mem   = (r == R_MEM || r == R_READY_MEM || r == R_ALL);
      tick();
      val_ready = 1'b0; val_conflito_borda = 1'b0; val_conflito_mem = 1'b0;
    end
    model_apply(r);
    check("enable_um_ciclo", val_enable, 0);
    check("latch_estavel", {val_x, val_y, val_direcao}, {x, y, d});
    check_model("resposta");
    tick();
  endtask

  vetor_t tabela [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int tipo_v;
    int iter;
    resp_e r;

    tabela[0] = '{4'd2,  4'd3,  1'b0, 3'd0, R_READY,     0, 1, 1'b0, 1'b0};
    tabela[1] = '{4'd9,  4'd1,  1'b1, 3'd0, R_BORDA,     1, 1, 1'b1, 1'b0};
    tabela[2] = '{4'd9,  4'd2,  1'b1, 3'd0, R_READY_MEM, 1, 1, 1'b0, 1'b1};
    tabela[3] = '{4'd9,  4'd2,  1'b0, 3'd0, R_READY,     1, 2, 1'b0, 1'b0};
    tabela[4] = '{4'd4,  4'd4,  1'b1, 3'd0, R_READY,     1, 3, 1'b0, 1'b0};
    tabela[5] = '{4'd5,  4'd5,  1'b0, 3'd2, R_MEM,       2, 3, 1'b0, 1'b1};
    tabela[6] = '{4'd5,  4'd6,  1'b0, 3'd3, R_READY,     2, 4, 1'b0, 1'b0};
    tabela[7] = '{4'd15, 4'd15, 1'b1, 3'd1, R_READY,     2, 5, 1'b0, 1'b0};
    tabela[8] = '{4'd0,  4'd0,  1'b0, 3'd0, R_ALL,       3, 5, 1'b1, 1'b0};

    model_reset();
    #12;
    check("reset_saidas", {val_enable, val_tipo, val_direcao, val_orientacao, val_x, val_y,
                           val_jogador, indice_peca, erro_borda, erro_memoria, erro_timeout,
                           ocupado, fase_concluida}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    watch_no_enable(4, "confirma_em_ocioso");

    pulse_iniciar();
    check_model("apos_iniciar");

    for (int i = 0; i < 9; i++) begin
      place(tabela[i].x, tabela[i].y, tabela[i].d, tabela[i].o, tabela[i].r, tipo_v);
      check($sformatf("tab%0d.tipo", i), tipo_v, tabela[i].tipo);
      check($sformatf("tab%0d.indice", i), indice_peca, tabela[i].idx);
      check($sformatf("tab%0d.erros", i), {erro_borda, erro_memoria}, {tabela[i].eb, tabela[i].em});
    end

    // No validator answer: timeout exactly 64 cycles after val_enable, index kept.
    place(4'd7, 4'd8, 1'b1, 3'd0, R_NONE, tipo_v);
    check("timeout_indice", indice_peca, 5);

    // Iniciar mid-phase is ignored.
    pulse_iniciar();
    tick();
    check_model("iniciar_ignorado");

    // Button held through the whole transaction does not retrigger.
    x_in = 4'd1; y_in = 4'd2; direcao_in = 1'b0; orientacao_in = 3'd0;
    confirmar = 1'b1;
    tick();
    tick();
    check("segurado_enable", val_enable, 1);
    m_eb = 1'b0; m_em = 1'b0; m_et = 1'b0;
    val_ready = 1'b1;
    tick();
    val_ready = 1'b0;
    model_apply(R_READY);
    watch_no_enable(5, "segurado_sem_repeticao");
    check_model("segurado");
    confirmar = 1'b0;
    tick();

    // Reset while waiting on the validator.
    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    tick();
    tick();
    check("pre_reset_ocupado", ocupado, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_assincrono", {val_enable, val_tipo, val_direcao, val_orientacao, val_x, val_y,
                               val_jogador, indice_peca, erro_borda, erro_memoria, erro_timeout,
                               ocupado, fase_concluida}, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    watch_no_enable(4, "confirma_apos_reset");
    check_model("apos_reset");

    // Randomized full phase: both fleets placed with random validator verdicts.
    pulse_iniciar();
    check_model("fase_inicio");
    iter = 0;
    while (!m_fase && iter < 300) begin
      case ($urandom_range(0, 9))
        6:       r = R_BORDA;
        7:       r = R_MEM;
        8:       r = R_READY_MEM;
        9:       r = R_ALL;
        default: r = R_READY;
      endcase
      place(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), r, tipo_v);
      iter++;
    end
    check("fase_final", fase_concluida, 1);
    check("fase_jogador", val_jogador, 1);

    // Confirms after completion are dropped and outputs hold.
    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    watch_no_enable(4, "confirma_em_fim");
    check_model("fim_estavel");

    // Iniciar from FIM restarts the phase.
    pulse_iniciar();
    model_reset();
    check_model("reinicio");
    place(4'd3, 4'd3, 1'b0, 3'd0, R_READY, tipo_v);
    check("reinicio_tipo", tipo_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
    $finish;
  end

endmodule
